// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader placed in front of the RISC-V core.
// Packs a little-endian byte stream into 32-bit words, writes them to
// instruction memory starting at word 0, and holds the core in reset until
// a complete, in-capacity load has finished.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   start               one-cycle load request (IDLE/DONE only)
//   byte_valid/data/last  incoming byte stream; byte_ready is the handshake
//   imem_we/addr/wdata  registered instruction-memory write port
//   cpu_rst_n           core reset, released only after a clean load
//   done, error         load finished / stream overflowed memory
//   words_loaded        words written by the most recent load
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | accepting bytes and writing packed words
// DRAIN | memory full, discarding bytes until byte_last
// DONE  | load finished; core released if no error
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t          state, state_next;
  logic [ADDR_W:0] ptr;
  logic [1:0]      lane;
  logic [23:0]     pack;
  logic            accept;
  logic            full;
  logic            wr;
  logic            err_set;
  logic            clear;
  logic [31:0]     word;

  assign byte_ready = (state == LOAD) || (state == DRAIN);
  assign accept     = byte_valid && byte_ready;
  // Pointer never wraps, so its top bit alone marks a full memory.
  assign full       = ptr[ADDR_W];

  // Upper lanes of pack are always zero ahead of the current lane because
  // pack is cleared on every word write, which gives zero-fill for free.
  always_comb begin
    word = {8'h00, pack};
    case (lane)
      2'd0: word[7:0]   = byte_data;
      2'd1: word[15:8]  = byte_data;
      2'd2: word[23:16] = byte_data;
      default: word[31:24] = byte_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    wr         = 1'b0;
    err_set    = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          clear      = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          if (full) begin
            err_set    = 1'b1;
            state_next = byte_last ? DONE : DRAIN;
          end else begin
            wr = (lane == 2'd3) || byte_last;
            if (byte_last) state_next = DONE;
          end
        end
      end
      DRAIN: begin
        if (accept && byte_last) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          state_next = LOAD;
          clear      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      lane         <= 2'd0;
      pack         <= 24'h0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'h0;
      error        <= 1'b0;
      done         <= 1'b0;
      cpu_rst_n    <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= wr;
      if (clear) begin
        ptr   <= '0;
        lane  <= 2'd0;
        pack  <= 24'h0;
        error <= 1'b0;
      end else if (state == LOAD && accept && !full) begin
        lane <= lane + 2'd1;
        if (wr) begin
          imem_addr  <= ptr[ADDR_W-1:0];
          imem_wdata <= word;
          ptr        <= ptr + 1'b1;
          pack       <= 24'h0;
        end else begin
          pack <= word[23:0];
        end
      end
      if (err_set) error <= 1'b1;
      // Status lags the DONE entry by one edge so the final write always
      // lands before the core is let out of reset.
      if (state == DONE && !start) begin
        done         <= 1'b1;
        cpu_rst_n    <= ~error;
        words_loaded <= ptr;
      end else begin
        done      <= 1'b0;
        cpu_rst_n <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, byte_valid, byte_last;
  logic [7:0]  byte_data;

  logic        byte_ready, imem_we, cpu_rst_n, done, error;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [10:0] words_loaded;

  logic        s_byte_ready, s_imem_we, s_cpu_rst_n, s_done, s_error;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_wdata;
  logic [2:0]  s_words_loaded;

  imem_loader #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n), .done(done),
    .error(error), .words_loaded(words_loaded)
  );

  imem_loader #(.ADDR_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(s_byte_ready), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
    .imem_wdata(s_imem_wdata), .cpu_rst_n(s_cpu_rst_n), .done(s_done),
    .error(s_error), .words_loaded(s_words_loaded)
  );

  always #5 clk = ~clk;

  logic [9:0]  la[$];
  logic [31:0] ld[$];
  logic [1:0]  sla[$];
  logic [31:0] sld[$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      la.push_back(imem_addr);
      ld.push_back(imem_wdata);
    end
    if (s_imem_we === 1'b1) begin
      sla.push_back(s_imem_addr);
      sld.push_back(s_imem_wdata);
    end
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = l;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    byte_data  = 8'hEE;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_logs();
    la.delete();
    ld.delete();
    sla.delete();
    sld.delete();
  endtask

  logic [7:0] two_words [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

  initial begin
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; byte_last = 1'b0;
    tick();
    check("rst_ready", byte_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_cpu", cpu_rst_n, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words", words_loaded, 0);
    rst_n = 1'b1;
    tick();

    // bytes offered in IDLE must be ignored
    byte_valid = 1'b1; byte_data = 8'h55; byte_last = 1'b1;
    tick(); tick();
    byte_valid = 1'b0; byte_last = 1'b0;
    check("idle_ready", byte_ready, 0);
    check("idle_done", done, 0);
    check("idle_nowrite", la.size(), 0);

    // two-word load
    pulse_start();
    check("start_ready", byte_ready, 1);
    for (int i = 0; i < 4; i++) send(two_words[i], 1'b0);
    check("w0_we", imem_we, 1);
    check("w0_addr", imem_addr, 0);
    check("w0_data", imem_wdata, 32'h00000013);
    for (int i = 4; i < 8; i++) send(two_words[i], i == 7);
    check("w1_we", imem_we, 1);
    check("w1_addr", imem_addr, 1);
    check("w1_data", imem_wdata, 32'h00100093);
    check("done_lag", done, 0);
    check("cpu_lag", cpu_rst_n, 0);
    tick();
    check("tw_we_width", imem_we, 0);
    check("tw_done", done, 1);
    check("tw_error", error, 0);
    check("tw_cpu", cpu_rst_n, 1);
    check("tw_words", words_loaded, 2);
    check("tw_words_s", s_words_loaded, 2);
    tick();
    check("tw_nwrites", la.size(), 2);
    check("tw_d0", ld[0], 32'h00000013);
    check("tw_a0", la[0], 0);
    check("tw_d1", ld[1], 32'h00100093);
    check("tw_a1", la[1], 1);

    // restart from DONE, partial last word, start ignored in LOAD
    clear_logs();
    pulse_start();
    check("rs_done", done, 0);
    check("rs_cpu", cpu_rst_n, 0);
    check("rs_ready", byte_ready, 1);
    send(8'h13, 1'b0);
    start = 1'b1;
    send(8'h00, 1'b0);
    start = 1'b0;
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'hAB, 1'b1);
    tick();
    check("pw_words", words_loaded, 2);
    check("pw_error", error, 0);
    check("pw_done", done, 1);
    tick();
    check("pw_nwrites", la.size(), 2);
    check("pw_d0", ld[0], 32'h00000013);
    check("pw_d1", ld[1], 32'h000000AB);
    check("pw_a1", la[1], 1);

    // backpressure: random gaps with junk data while byte_valid is low
    clear_logs();
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      send(two_words[i], i == 7);
    end
    tick(); tick();
    check("bp_words", words_loaded, 2);
    check("bp_nwrites", la.size(), 2);
    check("bp_d0", ld[0], 32'h00000013);
    check("bp_d1", ld[1], 32'h00100093);

    // overflow: 18 bytes into a 4-word memory (small instance)
    clear_logs();
    pulse_start();
    for (int i = 1; i <= 16; i++) send(8'(i), 1'b0);
    send(8'd17, 1'b0);
    check("ov_err_set", s_error, 1);
    check("ov_drain_ready", s_byte_ready, 1);
    check("ov_big_noerr", error, 0);
    send(8'd18, 1'b1);
    check("ov_no_write", s_imem_we, 0);
    check("ov_big_we", imem_we, 1);
    tick();
    check("ov_done", s_done, 1);
    check("ov_error", s_error, 1);
    check("ov_cpu", s_cpu_rst_n, 0);
    check("ov_words", s_words_loaded, 4);
    check("ov_big_words", words_loaded, 5);
    check("ov_big_cpu", cpu_rst_n, 1);
    tick();
    check("ov_nwrites", sla.size(), 4);
    check("ov_d0", sld[0], 32'h04030201);
    check("ov_d3", sld[3], 32'h100F0E0D);
    check("ov_a3", sla[3], 3);
    check("ov_big_nwrites", la.size(), 5);
    check("ov_big_d4", ld[4], 32'h00001211);
    check("ov_big_a4", la[4], 4);

    // reset mid-load, right after the third word's write strobe
    clear_logs();
    pulse_start();
    check("rm_err_clr", s_error, 0);
    for (int i = 0; i < 12; i++) send(8'h20 + 8'(i), 1'b0);
    check("rm_we_before", imem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rm_ready", byte_ready, 0);
    check("rm_we", imem_we, 0);
    check("rm_addr", imem_addr, 0);
    check("rm_wdata", imem_wdata, 0);
    check("rm_cpu", cpu_rst_n, 0);
    check("rm_done", done, 0);
    check("rm_words", words_loaded, 0);
    check("rm_words_s", s_words_loaded, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    clear_logs();
    pulse_start();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    tick();
    check("rl_words", words_loaded, 1);
    check("rl_done", done, 1);
    check("rl_cpu", cpu_rst_n, 1);
    tick();
    check("rl_nwrites", la.size(), 1);
    check("rl_d0", ld[0], 32'h04030201);
    check("rl_a0", la[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
